// File: rtl/i2c_pkg.sv
// Shared types and default timing constants for the single-byte I2C master sequencer.
package i2c_pkg;

    localparam int DEF_DIVIDER = 6500;
    localparam int DEF_CBITS   = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WRITE,
        S_WACK,
        S_READ,
        S_RNACK,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase bit timer: counter, wrap, update/sample strobes and SCL stretch hold.
// Stretch hold is compiled in only when I2C_STRETCH_EN is defined.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int DIVIDER = DEF_DIVIDER,
    parameter int CBITS   = DEF_CBITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_run,
    input  logic     i_stretch_ok,
    input  logic     i_scl_in,
    output quarter_t o_q,
    output logic     o_wrap,
    output logic     o_upd,
    output logic     o_smp
);

    localparam logic [CBITS-1:0] C_Q1   = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] C_Q2   = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] C_Q3   = CBITS'(3 * DIVIDER);
    localparam logic [CBITS-1:0] C_LAST = CBITS'(4 * DIVIDER - 1);

    logic [CBITS-1:0] r_cnt;
    logic             w_hold;

`ifdef I2C_STRETCH_EN
    // A slave holding SCL low at the start of the high phase freezes the bit timer.
    assign w_hold = i_run && i_stretch_ok && (r_cnt == C_Q2) && !i_scl_in;
`else
    logic w_unused_stretch;
    assign w_unused_stretch = i_scl_in ^ i_stretch_ok;
    assign w_hold           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else if (w_hold) begin
            r_cnt <= r_cnt;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        if (r_cnt < C_Q1) begin
            o_q = Q0;
        end else if (r_cnt < C_Q2) begin
            o_q = Q1;
        end else if (r_cnt < C_Q3) begin
            o_q = Q2;
        end else begin
            o_q = Q3;
        end
    end

    assign o_wrap = i_run && (r_cnt == C_LAST);
    assign o_upd  = i_run && (r_cnt == C_Q1);
    assign o_smp  = i_run && (r_cnt == C_Q3);

endmodule

// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: command handshake, START/addr/data/ACK/STOP sequencing, response.
// Optional clock-stretch support is selected with I2C_STRETCH_EN (see i2c_phase_gen).
module i2c_master_seq
    import i2c_pkg::*;
#(
    parameter int DIVIDER = DEF_DIVIDER,
    parameter int CBITS   = DEF_CBITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_t     r_state;
    state_t     w_state_nxt;
    quarter_t   w_q;
    logic       w_wrap;
    logic       w_upd;
    logic       w_smp;
    logic       w_run;
    logic       w_stretch_ok;
    logic       w_accept;
    logic       w_last_bit;
    logic       w_done;
    logic       w_scl_low;

    logic [7:0] r_tx;
    logic [7:0] r_wdata;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic       r_rw;
    logic       r_nack;
    logic       r_drv;
    logic       r_rsp_valid;
    logic       r_rsp_nack;
    logic [7:0] r_rsp_rdata;

    assign w_run        = (r_state != S_IDLE);
    assign w_stretch_ok = (r_state != S_START);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_last_bit   = (r_bit == 3'd7);
    assign w_done       = (r_state == S_STOP) && w_wrap;
    assign w_scl_low    = (w_q == Q0) || (w_q == Q1);

    i2c_phase_gen #(
        .DIVIDER (DIVIDER),
        .CBITS   (CBITS)
    ) u_phase (
        .clk          (clk),
        .rst          (rst),
        .i_run        (w_run),
        .i_stretch_ok (w_stretch_ok),
        .i_scl_in     (scl_in),
        .o_q          (w_q),
        .o_wrap       (w_wrap),
        .o_upd        (w_upd),
        .o_smp        (w_smp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_START;
            S_START: if (w_wrap) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_wrap && w_last_bit) w_state_nxt = S_AACK;
            S_AACK:  if (w_wrap) w_state_nxt = r_nack ? S_STOP : (r_rw ? S_READ : S_WRITE);
            S_WRITE: if (w_wrap && w_last_bit) w_state_nxt = S_WACK;
            S_WACK:  if (w_wrap) w_state_nxt = S_STOP;
            S_READ:  if (w_wrap && w_last_bit) w_state_nxt = S_RNACK;
            S_RNACK: if (w_wrap) w_state_nxt = S_STOP;
            S_STOP:  if (w_wrap) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The cycle carrying rsp_valid is not an accept slot, so back-to-back commands start one cycle later.
    always_comb begin
        cmd_ready = (r_state == S_IDLE) && !rst && !r_rsp_valid;
        busy      = (r_state != S_IDLE);
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (r_state)
            S_START: begin
                sda_oe = (w_q == Q2) || (w_q == Q3);
            end
            S_STOP: begin
                scl_oe = w_scl_low;
                sda_oe = (w_q != Q3);
            end
            S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_RNACK: begin
                scl_oe = w_scl_low;
                sda_oe = r_drv;
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // r_drv starts asserted so SDA stays low from START into the first address bit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tx    <= {cmd_addr, cmd_rw};
            r_wdata <= cmd_wdata;
            r_rw    <= cmd_rw;
            r_nack  <= 1'b0;
            r_rx    <= 8'd0;
            r_bit   <= 3'd0;
            r_drv   <= 1'b1;
        end else begin
            if (w_upd) begin
                case (r_state)
                    S_ADDR, S_WRITE:                 r_drv <= ~r_tx[7];
                    S_AACK, S_WACK, S_READ, S_RNACK: r_drv <= 1'b0;
                    default:                         r_drv <= r_drv;
                endcase
            end
            if (w_smp) begin
                case (r_state)
                    S_AACK, S_WACK: if (sda_in) r_nack <= 1'b1;
                    S_READ:         r_rx <= {r_rx[6:0], sda_in};
                    default:        r_rx <= r_rx;
                endcase
            end
            if (w_wrap) begin
                case (r_state)
                    S_ADDR, S_WRITE: begin
                        r_tx  <= r_tx << 1;
                        r_bit <= r_bit + 3'd1;
                    end
                    S_READ:  r_bit <= r_bit + 3'd1;
                    S_AACK:  r_tx  <= r_wdata;
                    default: r_bit <= r_bit;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_nack  <= 1'b0;
            r_rsp_rdata <= 8'd0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_nack  <= r_nack;
                r_rsp_rdata <= r_rx;
            end else if (w_accept) begin
                r_rsp_nack  <= 1'b0;
                r_rsp_rdata <= 8'd0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_nack  = r_rsp_nack;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq at DIVIDER=4 with a timed slave model on the open-drain bus.
module tb_i2c_master_seq;

    localparam int DIV = 4;
`ifdef I2C_STRETCH_EN
    localparam bit STRETCH_ON = 1'b1;
`else
    localparam bit STRETCH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;
    logic       slv_scl = 1'b0;
    logic       slv_sda = 1'b0;

    assign scl_in = ~(scl_oe | slv_scl);
    assign sda_in = ~(sda_oe | slv_sda);

    i2c_master_seq #(
        .DIVIDER (DIV),
        .CBITS   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         g_t = 0;
    logic       g_rw = 1'b0;
    logic       g_acka = 1'b0;
    logic       g_ackd = 1'b0;
    logic       g_stretch = 1'b0;
    logic [7:0] g_sdata = 8'd0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Bit-period time as the DUT sees it, removing the cycles lost to a stretch.
    function automatic int rel_t();
        int ext;
        ext = (g_stretch && STRETCH_ON && g_t >= 82) ? 10 : 0;
        return g_t - ext;
    endfunction

    task automatic set_pulls();
        int rt;
        int b;
        rt = rel_t();
        b  = (rt < 0) ? -1 : rt / 16;
        slv_sda = 1'b0;
        if (b == 9 && g_acka) slv_sda = 1'b1;
        if (!g_rw && b == 18 && g_ackd) slv_sda = 1'b1;
        if (g_rw && b >= 10 && b <= 17) slv_sda = ~g_sdata[17-b];
        slv_scl = g_stretch && (g_t >= 72) && (g_t < 82);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        g_t++;
        set_pulls();
    endtask

    task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                             input logic acka, input logic ackd, input logic [7:0] sdata,
                             input logic stretch);
        g_rw      = rw;
        g_acka    = acka;
        g_ackd    = ackd;
        g_sdata   = sdata;
        g_stretch = stretch;
        g_t       = -1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(output int rsp_t, output logic [7:0] ab, output logic [7:0] db,
                           output logic rn_rel, output logic [1:0] stop_sda);
        int rt;
        int b;
        int p;
        rsp_t    = -1;
        ab       = 8'd0;
        db       = 8'd0;
        rn_rel   = 1'b0;
        stop_sda = 2'b00;
        while (rsp_t < 0 && g_t < 500) begin
            rt = rel_t();
            b  = rt / 16;
            p  = rt % 16;
            if (p == 3 * DIV) begin
                if (b >= 1 && b <= 8) ab[8-b] = ~sda_oe;
                if (b >= 10 && b <= 17) db[17-b] = ~sda_oe;
                if (b == 18) rn_rel = ~sda_oe;
            end
            if (b == 19 && p == 3 * DIV - 1) stop_sda[1] = sda_oe;
            if (b == 19 && p == 3 * DIV) stop_sda[0] = sda_oe;
            if (rsp_valid) rsp_t = g_t;
            else step();
        end
        g_acka    = 1'b0;
        g_ackd    = 1'b0;
        g_stretch = 1'b0;
        g_rw      = 1'b0;
    endtask

    int         lat;
    logic [7:0] ab;
    logic [7:0] db;
    logic       rn;
    logic [1:0] sp;
    int         n_acc;
    int         a1;
    int         a2;
    int         rc;
    int         k;
    logic       seen;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready_low", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_scl_oe", scl_oe, 0);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_nack", rsp_nack, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);

        // Write 0x50 <- 0xA5, both bytes ACKed.
        start_cmd(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
        run_txn(lat, ab, db, rn, sp);
        check_val("wr_addr_bits", ab, 8'hA0);
        check_val("wr_data_bits", db, 8'hA5);
        check_val("wr_latency", lat, 320);
        check_val("wr_nack", rsp_nack, 0);
        check_val("wr_rdata", rsp_rdata, 0);
        check_val("wr_stop_sda", sp, 2'b10);
        step();
        check_val("wr_pulse_len", rsp_valid, 0);

        // Address NACK.
        start_cmd(7'h22, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
        run_txn(lat, ab, db, rn, sp);
        check_val("nak_addr_bits", ab, 8'h44);
        check_val("nak_latency", lat, 176);
        check_val("nak_nack", rsp_nack, 1);
        check_val("nak_rdata", rsp_rdata, 0);
        step();
        check_val("nak_hold", rsp_nack, 1);

        // Read 0x51, slave returns 0x3C.
        start_cmd(7'h51, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
        run_txn(lat, ab, db, rn, sp);
        check_val("rd_addr_bits", ab, 8'hA3);
        check_val("rd_latency", lat, 320);
        check_val("rd_rdata", rsp_rdata, 8'h3C);
        check_val("rd_nack", rsp_nack, 0);
        check_val("rd_rnack_released", rn, 1);
        step();
        check_val("rd_hold", rsp_rdata, 8'h3C);

        // Slave stretches SCL for 10 cycles in address bit 3.
        start_cmd(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1);
        run_txn(lat, ab, db, rn, sp);
        check_val("st_latency", lat, STRETCH_ON ? 330 : 320);
        check_val("st_data_bits", db, 8'hA5);
        check_val("st_nack", rsp_nack, 0);
        step();

        // Reset pulsed during write bit 4.
        start_cmd(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
        while (g_t < 14 * 16 + 6) step();
        check_val("mid_busy", busy, 1);
        check_val("mid_sda_oe", sda_oe, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        g_acka = 1'b0;
        g_ackd = 1'b0;
        set_pulls();
        #1;
        check_val("mrst_scl_oe", scl_oe, 0);
        check_val("mrst_sda_oe", sda_oe, 0);
        check_val("mrst_busy", busy, 0);
        check_val("mrst_ready", cmd_ready, 1);
        seen = 1'b0;
        repeat (400) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check_val("mrst_no_rsp", seen, 0);

        // cmd_valid held high across a NACKed transfer.
        cmd_addr  = 7'h22;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h00;
        g_t       = -1000;
        cmd_valid = 1'b1;
        n_acc = 0;
        a1 = -1;
        a2 = -1;
        rc = -1;
        k  = 0;
        while (n_acc < 2 && k < 400) begin
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                if (n_acc == 1) a1 = cyc;
                else a2 = cyc;
            end
            if (rsp_valid) rc = cyc;
            if (n_acc < 2) step();
            k++;
        end
        check_val("hold_accepts", n_acc, 2);
        check_val("hold_rsp_cycle", rc - a1, 177);
        check_val("hold_second_accept", a2 - a1, 178);
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
